// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes, write-path states and the
// response returned for accesses that miss the register window.
// Behaviour of out-of-range accesses depends on AXI_LITE_REGFILE_ADDR_ERR_EN.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wstate_t;

  // Response for an index beyond the last register
  function automatic logic [1:0] oor_resp();
`ifdef AXI_LITE_REGFILE_ADDR_ERR_EN
    return RESP_SLVERR;
`else
    return RESP_OKAY;
`endif
  endfunction

endpackage

// File: rtl/axi_lite_strb_merge.sv
// Byte-lane merge: lanes with a set strobe take the new byte, others keep the old.
module axi_lite_strb_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_val,
  input  logic [DATA_W-1:0]   new_val,
  input  logic [DATA_W/8-1:0] strb,
  output logic [DATA_W-1:0]   merged
);

  // Start from the old word and overwrite only the enabled lanes
  always_comb begin
    merged = old_val;
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (strb[i]) merged[i*8 +: 8] = new_val[i*8 +: 8];
    end
  end

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI-Lite register file with independent read and write paths.
// Writes accept AW and W in any order; the commit happens as soon as both are
// known and the response follows one cycle later. Reads respond one cycle
// after the AR handshake. Define AXI_LITE_REGFILE_ADDR_ERR_EN to report
// SLVERR for out-of-range indices (otherwise OKAY with dropped writes).
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [ADDR_W-1:0]         awaddr,
  input  logic [2:0]                awprot,
  input  logic                      wvalid,
  output logic                      wready,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W/8-1:0]       wstrb,
  output logic                      bvalid,
  input  logic                      bready,
  output logic [1:0]                bresp,
  input  logic                      arvalid,
  output logic                      arready,
  input  logic [ADDR_W-1:0]         araddr,
  input  logic [2:0]                arprot,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [DATA_W-1:0]         rdata,
  output logic [1:0]                rresp,
  output logic [REG_NUM*DATA_W-1:0] regs_o,
  output logic [REG_NUM-1:0]        wr_pulse_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int IDX_W  = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

  logic                rdy;
  wstate_t             wstate, wnext;
  logic [ADDR_W-1:0]   awaddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   regs [REG_NUM];

  logic                aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_W-1:0]   c_addr, widx_full, ridx_full;
  logic [DATA_W-1:0]   c_data, old_val, merged;
  logic [STRB_W-1:0]   c_strb;
  logic [IDX_W-1:0]    widx, ridx;
  logic                w_inr, r_inr;
  logic                unused_prot;

  assign unused_prot = ^{awprot, arprot};

  assign awready = rdy && (wstate == W_IDLE || wstate == W_HAVE_W);
  assign wready  = rdy && (wstate == W_IDLE || wstate == W_HAVE_AW);
  assign bvalid  = (wstate == W_RESP);
  assign arready = rdy && !rvalid;

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign ar_hs  = arvalid && arready;
  assign commit = (aw_hs || wstate == W_HAVE_AW) && (w_hs || wstate == W_HAVE_W);

  // A channel arriving this cycle is used directly, otherwise its held copy
  assign c_addr    = aw_hs ? awaddr : awaddr_q;
  assign c_data    = w_hs ? wdata : wdata_q;
  assign c_strb    = w_hs ? wstrb : wstrb_q;
  assign widx_full = c_addr >> OFF;
  assign widx      = widx_full[IDX_W-1:0];
  assign w_inr     = 32'(widx_full) < REG_NUM;
  assign old_val   = w_inr ? regs[widx] : '0;

  assign ridx_full = araddr >> OFF;
  assign ridx      = ridx_full[IDX_W-1:0];
  assign r_inr     = 32'(ridx_full) < REG_NUM;

  axi_lite_strb_merge #(.DATA_W(DATA_W)) u_merge (
    .old_val (old_val),
    .new_val (c_data),
    .strb    (c_strb),
    .merged  (merged)
  );

  for (genvar g = 0; g < REG_NUM; g++) begin : g_flat
    assign regs_o[g*DATA_W +: DATA_W] = regs[g];
  end

  // Write-path state register; ready flag opens the channels after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate <= W_IDLE;
      rdy    <= 1'b0;
    end else begin
      wstate <= wnext;
      rdy    <= 1'b1;
    end
  end

  // Write-path next state: collect AW and W, then wait for the response accept
  always_comb begin
    wnext = wstate;
    case (wstate)
      W_IDLE: begin
        if (aw_hs && w_hs) wnext = W_RESP;
        else if (aw_hs)    wnext = W_HAVE_AW;
        else if (w_hs)     wnext = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)  wnext = W_RESP;
      W_HAVE_W:  if (aw_hs) wnext = W_RESP;
      W_RESP:    if (bready) wnext = W_IDLE;
      default:   wnext = W_IDLE;
    endcase
  end

  // Holding registers, write response code and commit strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp      <= RESP_OKAY;
      wr_pulse_o <= '0;
    end else begin
      if (aw_hs) awaddr_q <= awaddr;
      if (w_hs) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      wr_pulse_o <= '0;
      if (commit) begin
        bresp <= w_inr ? RESP_OKAY : oor_resp();
        if (w_inr) wr_pulse_o[widx] <= 1'b1;
      end
    end
  end

  // Register storage; out-of-range writes leave everything untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (commit && w_inr) begin
      regs[widx] <= merged;
    end
  end

  // Read path: capture the pre-write register value on AR, hold until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rdata  <= r_inr ? regs[ridx] : '0;
      rresp  <= r_inr ? RESP_OKAY : oor_resp();
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Self-checking bench for axi_lite_regfile against a word-array reference model.
module tb_axi_lite_regfile;
  import axi_lite_pkg::*;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int REG_NUM = 16;

`ifdef AXI_LITE_REGFILE_ADDR_ERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic                      arvalid = 1'b0, rready = 1'b0;
  logic                      awready, wready, bvalid, arready, rvalid;
  logic [ADDR_W-1:0]         awaddr = '0, araddr = '0;
  logic [2:0]                awprot = 3'd0, arprot = 3'd0;
  logic [DATA_W-1:0]         wdata = '0;
  logic [DATA_W/8-1:0]       wstrb = '0;
  logic [1:0]                bresp, rresp;
  logic [DATA_W-1:0]         rdata;
  logic [REG_NUM*DATA_W-1:0] regs_o;
  logic [REG_NUM-1:0]        wr_pulse_o;

  logic [31:0] model [REG_NUM];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_lite_regfile #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_NUM(REG_NUM)) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
  );

  // Spec rule: enabled byte lanes take new data, via a mask
  function automatic logic [31:0] merge_model(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~mask) | (n & mask);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one write; latency counts edges from the later handshake to bvalid
  task automatic write_txn(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output int lat, output logic [1:0] resp,
                           output logic [15:0] pulse_first, output logic [15:0] pulse_next,
                           output bit ok);
    bit aw_ok, w_ok;
    aw_ok = 0;
    w_ok = 0;
    fork
      begin
        bit hs;
        repeat (aw_dly) tick();
        awaddr = addr;
        awvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
          hs = awready;
          tick();
          if (hs) begin aw_ok = 1; break; end
        end
        awvalid = 1'b0;
      end
      begin
        bit hs;
        repeat (w_dly) tick();
        wdata = data;
        wstrb = strb;
        wvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
          hs = wready;
          tick();
          if (hs) begin w_ok = 1; break; end
        end
        wvalid = 1'b0;
      end
    join
    lat = 1;
    while (!bvalid && lat < 20) begin
      tick();
      lat++;
    end
    ok = aw_ok && w_ok && bvalid;
    resp = bresp;
    pulse_first = wr_pulse_o;
    if (b_dly == 0) begin
      bready = 1'b1;
      tick();
      pulse_next = wr_pulse_o;
      bready = 1'b0;
    end else begin
      tick();
      pulse_next = wr_pulse_o;
      repeat (b_dly - 1) tick();
      bready = 1'b1;
      tick();
      bready = 1'b0;
    end
  endtask

  // Drives one read, optionally stalling rready, and reports what was seen
  task automatic read_txn(input logic [7:0] addr, input int stall,
                          output logic [31:0] data, output logic [1:0] resp, output int lat,
                          output bit stable, output bit ar_low, output bit ar_after, output bit ok);
    bit hs, ar_ok;
    ar_ok = 0;
    araddr = addr;
    arvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      hs = arready;
      tick();
      if (hs) begin ar_ok = 1; break; end
    end
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 20) begin
      tick();
      lat++;
    end
    ok = ar_ok && rvalid;
    data = rdata;
    resp = rresp;
    stable = 1;
    ar_low = (arready === 1'b0);
    repeat (stall) begin
      tick();
      if (rdata !== data || rresp !== resp || rvalid !== 1'b1) stable = 0;
      if (arready !== 1'b0) ar_low = 0;
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    ar_after = (arready === 1'b1) && (rvalid === 1'b0);
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_handshakes got %b want 00000", {awready, wready, arready, bvalid, rvalid});
    end
    checks++;
    if (regs_o !== '0 || wr_pulse_o !== '0 || rdata !== '0 || bresp !== 2'b00 || rresp !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_state regs_o=%h pulse=%h rdata=%h bresp=%b rresp=%b want all zero",
               regs_o, wr_pulse_o, rdata, bresp, rresp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL reset_release_ready got %b want 111", {awready, wready, arready});
    end
    for (int i = 0; i < REG_NUM; i++) model[i] = '0;
  endtask

  task automatic test_same_cycle_write();
    int lat; logic [1:0] resp; logic [15:0] p1, p2; bit ok;
    write_txn(8'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, lat, resp, p1, p2, ok);
    model[1] = merge_model(model[1], 32'hDEADBEEF, 4'hF);
    checks++;
    if (!ok || lat != 1) begin
      errors++;
      $display("[TB] FAIL same_cycle_latency got %0d (ok=%0d) want 1", lat, ok);
    end
    checks++;
    if (resp !== RESP_OKAY) begin
      errors++;
      $display("[TB] FAIL same_cycle_bresp got %b want 00", resp);
    end
    checks++;
    if (regs_o[1*32 +: 32] !== model[1]) begin
      errors++;
      $display("[TB] FAIL same_cycle_reg1 got %h want %h", regs_o[1*32 +: 32], model[1]);
    end
    checks++;
    if (p1 !== 16'h0002 || p2 !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL same_cycle_pulse got %h then %h want 0002 then 0000", p1, p2);
    end
  endtask

  task automatic test_w_first();
    int lat; logic [1:0] resp; logic [15:0] p1, p2; bit ok;
    write_txn(8'h08, 32'h000000AA, 4'h1, 3, 0, 0, lat, resp, p1, p2, ok);
    model[2] = merge_model(model[2], 32'h000000AA, 4'h1);
    checks++;
    if (!ok || lat != 1) begin
      errors++;
      $display("[TB] FAIL w_first_latency got %0d (ok=%0d) want 1", lat, ok);
    end
    checks++;
    if (regs_o[2*32 +: 32] !== model[2] || model[2] !== 32'h000000AA) begin
      errors++;
      $display("[TB] FAIL w_first_reg2 got %h want %h", regs_o[2*32 +: 32], 32'h000000AA);
    end
    checks++;
    if (resp !== RESP_OKAY || p1 !== 16'h0004) begin
      errors++;
      $display("[TB] FAIL w_first_resp_pulse got resp=%b pulse=%h want 00 0004", resp, p1);
    end
  endtask

  task automatic test_read_stall();
    logic [31:0] d; logic [1:0] resp; int lat; bit st, lo, af, ok;
    read_txn(8'h04, 5, d, resp, lat, st, lo, af, ok);
    checks++;
    if (!ok || lat != 1 || d !== 32'hDEADBEEF || resp !== RESP_OKAY) begin
      errors++;
      $display("[TB] FAIL read_stall_data got %h resp=%b lat=%0d want deadbeef 00 1", d, resp, lat);
    end
    checks++;
    if (!st || !lo) begin
      errors++;
      $display("[TB] FAIL read_stall_hold got stable=%0d arready_low=%0d want 1 1", st, lo);
    end
    checks++;
    if (!af) begin
      errors++;
      $display("[TB] FAIL read_stall_arready_after got %0d want 1", af);
    end
  endtask

  task automatic test_out_of_range();
    int lat; logic [1:0] resp; logic [15:0] p1, p2; bit ok;
    logic [31:0] d; bit st, lo, af;
    logic [REG_NUM*DATA_W-1:0] snap;
    snap = regs_o;
    write_txn(8'h40, $urandom, 4'hF, 0, 0, 1, lat, resp, p1, p2, ok);
    checks++;
    if (!ok || resp !== OOR_RESP || p1 !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL oor_write got resp=%b pulse=%h ok=%0d want %b 0000", resp, p1, ok, OOR_RESP);
    end
    checks++;
    if (regs_o !== snap) begin
      errors++;
      $display("[TB] FAIL oor_regs_unchanged got %h want %h", regs_o, snap);
    end
    read_txn(8'h40, 0, d, resp, lat, st, lo, af, ok);
    checks++;
    if (!ok || d !== 32'h0 || resp !== OOR_RESP) begin
      errors++;
      $display("[TB] FAIL oor_read got %h resp=%b want 00000000 %b", d, resp, OOR_RESP);
    end
  endtask

  task automatic test_collision();
    int lat; logic [1:0] resp; logic [15:0] p1, p2; bit ok;
    logic [31:0] d; bit st, lo, af;
    write_txn(8'h0C, 32'h11111111, 4'hF, 0, 0, 0, lat, resp, p1, p2, ok);
    model[3] = 32'h11111111;
    awaddr = 8'h0C; wdata = 32'h22222222; wstrb = 4'hF; araddr = 8'h0C;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    ok = awready && wready && arready;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    model[3] = 32'h22222222;
    checks++;
    if (!ok || rvalid !== 1'b1 || bvalid !== 1'b1 || rdata !== 32'h11111111) begin
      errors++;
      $display("[TB] FAIL collision_old_value got rdata=%h rvalid=%b bvalid=%b ready=%0d want 11111111 1 1",
               rdata, rvalid, bvalid, ok);
    end
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    read_txn(8'h0C, 0, d, resp, lat, st, lo, af, ok);
    checks++;
    if (!ok || d !== model[3]) begin
      errors++;
      $display("[TB] FAIL collision_new_value got %h want %h", d, model[3]);
    end
  endtask

  task automatic test_random();
    int lat; logic [1:0] resp; logic [15:0] p1, p2; bit ok;
    logic [31:0] d, wd; bit st, lo, af;
    logic [7:0] addr; logic [3:0] strb; int idx;
    for (int it = 0; it < 40; it++) begin
      addr = 8'($urandom_range(0, 8'h4F));
      idx = int'(addr) / 4;
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom;
        strb = 4'($urandom_range(0, 15));
        write_txn(addr, wd, strb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                  lat, resp, p1, p2, ok);
        if (idx < REG_NUM) model[idx] = merge_model(model[idx], wd, strb);
        checks++;
        if (!ok || lat != 1 || resp !== ((idx < REG_NUM) ? RESP_OKAY : OOR_RESP) ||
            p1 !== ((idx < REG_NUM) ? (16'h1 << idx) : 16'h0)) begin
          errors++;
          $display("[TB] FAIL random_write addr=%h got lat=%0d resp=%b pulse=%h ok=%0d", addr, lat, resp, p1, ok);
        end
      end else begin
        read_txn(addr, $urandom_range(0, 2), d, resp, lat, st, lo, af, ok);
        checks++;
        if (!ok || lat != 1 || d !== ((idx < REG_NUM) ? model[idx] : 32'h0) ||
            resp !== ((idx < REG_NUM) ? RESP_OKAY : OOR_RESP)) begin
          errors++;
          $display("[TB] FAIL random_read addr=%h got %h resp=%b want %h", addr, d, resp,
                   (idx < REG_NUM) ? model[idx] : 32'h0);
        end
      end
    end
    for (int i = 0; i < REG_NUM; i++) begin
      checks++;
      if (regs_o[i*32 +: 32] !== model[i]) begin
        errors++;
        $display("[TB] FAIL random_final_reg%0d got %h want %h", i, regs_o[i*32 +: 32], model[i]);
      end
    end
  endtask

  task automatic test_reset_in_flight();
    logic [31:0] d; logic [1:0] resp; int lat; bit st, lo, af, ok;
    awaddr = 8'h08; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL inflight_bvalid got %b want 1", bvalid);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bvalid, awready, wready, arready} !== 4'b0 || regs_o !== '0) begin
      errors++;
      $display("[TB] FAIL inflight_reset got b/aw/w/ar=%b regs_o=%h want 0000 and zero",
               {bvalid, awready, wready, arready}, regs_o);
    end
    for (int i = 0; i < REG_NUM; i++) model[i] = '0;
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (bvalid !== 1'b0 || {awready, wready, arready} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL inflight_release got bvalid=%b ready=%b want 0 111", bvalid, {awready, wready, arready});
    end
    for (int i = 1; i < 4; i++) begin
      read_txn(8'(i * 4), 0, d, resp, lat, st, lo, af, ok);
      checks++;
      if (!ok || d !== model[i]) begin
        errors++;
        $display("[TB] FAIL inflight_read_reg%0d got %h want %h", i, d, model[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_same_cycle_write();
    test_w_first();
    test_read_stall();
    test_out_of_range();
    test_collision();
    test_random();
    test_reset_in_flight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a stuck handshake stalling the run
  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired after %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
